// File: rtl/uart_frame_tx.sv
// Parametrised UART transmitter: DATA_BITS data bits LSB first, optional parity, 1/2 stop bits,
// valid/ready input with gapless back-to-back frames. Define UART_TX_BREAK_EN for line-break support.
module uart_frame_tx #(
   parameter int CLK_FREQ    = 50000000,
   parameter int BAUD_RATE   = 9600,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic                 tx_done,
`ifdef UART_TX_BREAK_EN
   input  logic                 tx_break,
`endif
   output logic                 rs232_tx
);

   localparam int BPS = CLK_FREQ / BAUD_RATE;
   localparam int CW  = (BPS > 1) ? $clog2(BPS) : 1;

   generate
      if (BPS < 2) begin : g_bad_bps
         $error("uart_frame_tx: CLK_FREQ/BAUD_RATE must be >= 2");
      end
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
         $error("uart_frame_tx: DATA_BITS must be 5..9");
      end
      if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
         $error("uart_frame_tx: PARITY_MODE must be 0, 1 or 2");
      end
      if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
         $error("uart_frame_tx: STOP_BITS must be 1 or 2");
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         baud_q, baud_d;
   logic [3:0]            bit_q, bit_d;
   logic [DATA_BITS-1:0]  shift_q, shift_d;
   logic                  par_q, par_d;
   logic                  tx_q, tx_d;
   logic                  done_q, done_d;
   logic                  brk_q, brk_d;
   logic                  brk_in;
   logic                  bit_end, last_stop, accept;

`ifdef UART_TX_BREAK_EN
   assign brk_in = tx_break;
`else
   assign brk_in = 1'b0;
`endif

   assign bit_end   = (baud_q == CW'(BPS - 1));
   assign last_stop = (state_q == S_STOP) && bit_end && (bit_q == 4'(STOP_BITS - 1));
   // A pending or held break blocks new frames only while idle.
   assign tx_ready  = ((state_q == S_IDLE) && !brk_in && !brk_q) || last_stop;
   assign accept    = tx_valid && tx_ready;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      brk_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            baud_d = '0;
            brk_d  = brk_in;
            tx_d   = !brk_in;
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == 4'(DATA_BITS - 1)) begin
                  bit_d = '0;
                  if (PARITY_MODE != 0) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
                  bit_d   = bit_q + 4'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (last_stop) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Acceptance overrides whatever IDLE/STOP chose: start bit goes out next cycle.
      if (accept) begin
         state_d = S_START;
         baud_d  = '0;
         bit_d   = '0;
         shift_d = tx_data;
         par_d   = (^tx_data) ^ (PARITY_MODE == 1);
         tx_d    = 1'b0;
         brk_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         brk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         brk_q   <= brk_d;
      end
   end

   assign rs232_tx = tx_q;
   assign tx_busy  = (state_q != S_IDLE);
   assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: four instances (8N1, 8E1, 8O1, 7N2) at BPS=10, each checked every
// cycle against a frame-level model, plus hand-computed literal checks of timing and line bits.
module tb_uart_frame_tx;
   localparam int NI  = 4;
   localparam int BPS = 10;
`ifdef UART_TX_BREAK_EN
   localparam bit BRK_EN = 1'b1;
`else
   localparam bit BRK_EN = 1'b0;
`endif

   function automatic int db_of(input int i); return (i == 3) ? 7 : 8; endfunction
   function automatic int pm_of(input int i); return (i == 1) ? 2 : ((i == 2) ? 1 : 0); endfunction
   function automatic int sb_of(input int i); return (i == 3) ? 2 : 1; endfunction
   function automatic int nb_of(input int i);
      return 1 + db_of(i) + ((pm_of(i) != 0) ? 1 : 0) + sb_of(i);
   endfunction

   // Frame as a bit vector, bit 0 first on the line.
   function automatic logic [15:0] frame_of(input int i, input logic [8:0] w);
      logic [15:0] f;
      logic p;
      int idx;
      f = '0; p = 1'b0;
      for (int k = 0; k < db_of(i); k++) begin
         f[1+k] = w[k];
         p = p ^ w[k];
      end
      idx = 1 + db_of(i);
      if (pm_of(i) != 0) begin
         f[idx] = (pm_of(i) == 1) ? ~p : p;
         idx++;
      end
      for (int s = 0; s < sb_of(i); s++) f[idx+s] = 1'b1;
      return f;
   endfunction

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid [NI];
   logic [8:0] data  [NI];
   logic       brk   [NI];
   logic       ready [NI];
   logic       busy  [NI];
   logic       done  [NI];
   logic       line  [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      uart_frame_tx #(
         .CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(db_of(g)),
         .PARITY_MODE(pm_of(g)), .STOP_BITS(sb_of(g))
      ) u_dut (
         .clk_in(clk), .rst_n_in(rst_n), .tx_valid(valid[g]),
         .tx_data(data[g][db_of(g)-1:0]), .tx_ready(ready[g]), .tx_busy(busy[g]),
         .tx_done(done[g]),
`ifdef UART_TX_BREAK_EN
         .tx_break(brk[g]),
`endif
         .rs232_tx(line[g])
      );
   end

   int tests = 0, fails = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Model state: cycles left in the current frame, its bits, pending done, break held.
   int          rem     [NI];
   logic [15:0] fb      [NI];
   bit          dp      [NI];
   bit          bst     [NI];
   int          acc_cnt [NI];
   int          acc_cyc [NI];

   initial begin
      for (int i = 0; i < NI; i++) begin
         rem[i] = 0; fb[i] = '0; dp[i] = 0; bst[i] = 0; acc_cnt[i] = 0; acc_cyc[i] = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            logic el, er, eb, acc, dn;
            int pos;
            if (rem[i] > 0) begin
               pos = nb_of(i) * BPS - rem[i];
               el  = fb[i][pos / BPS];
            end else el = !bst[i];
            er = (rem[i] == 1) || (rem[i] == 0 && !bst[i] && !(BRK_EN && brk[i]));
            eb = (rem[i] > 0);
            if (chk_en) begin
               chk($sformatf("line%0d", i),  line[i],  el);
               chk($sformatf("ready%0d", i), ready[i], er);
               chk($sformatf("busy%0d", i),  busy[i],  eb);
               chk($sformatf("done%0d", i),  done[i],  dp[i]);
            end
            if (!rst_n) begin
               rem[i] = 0; dp[i] = 0; bst[i] = 0;
            end else begin
               acc = valid[i] && er;
               dn  = (rem[i] == 1);
               bst[i] = (rem[i] == 0 && !acc) ? (BRK_EN && brk[i]) : 1'b0;
               if (rem[i] > 0) rem[i]--;
               if (acc) begin
                  fb[i] = frame_of(i, data[i]);
                  rem[i] = nb_of(i) * BPS;
                  acc_cnt[i]++;
                  acc_cyc[i] = cyc + 1;
               end
               dp[i] = dn;
            end
         end
      end
   end

   task automatic at_cyc(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   task automatic to_edge(input int c);
      while (cyc < c) begin @(posedge clk); #1; end
   endtask

   task automatic wait_acc(input int i, input int n0, output int a);
      int t = 0;
      while (acc_cnt[i] == n0 && t < 400) begin @(posedge clk); #1; t++; end
      chk($sformatf("accept%0d", i), acc_cnt[i] - n0, 1);
      a = acc_cyc[i];
   endtask

   task automatic send(input int i, input logic [8:0] w, output int a);
      int n0;
      @(posedge clk); #1;
      valid[i] = 1'b1; data[i] = w; n0 = acc_cnt[i];
      wait_acc(i, n0, a);
      valid[i] = 1'b0;
   endtask

   initial begin
      int a, a1, a2, b, n0, z;
      logic [9:0] la5;
      for (int i = 0; i < NI; i++) begin valid[i] = 0; data[i] = '0; brk[i] = 0; end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk_en = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk("rst_line", line[i], 1); chk("rst_ready", ready[i], 1);
         chk("rst_busy", busy[i], 0); chk("rst_done", done[i], 0);
      end
      @(posedge clk); #1 rst_n = 1'b1;

      // 8N1 0xA5
      chk("model_a5", frame_of(0, 9'hA5), 16'h034A);
      la5 = 10'b11_0100_1010;
      send(0, 9'hA5, a);
      for (int k = 0; k < 10; k++) begin
         at_cyc(a + k * 10 + 4);
         chk($sformatf("a5_bit%0d", k), line[0], la5[k]);
      end
      at_cyc(a + 98);  chk("a5_ready_c99", ready[0], 0);
      at_cyc(a + 99);  chk("a5_ready_c100", ready[0], 1); chk("a5_done_c100", done[0], 0);
      at_cyc(a + 100); chk("a5_done_c101", done[0], 1); chk("a5_busy_c101", busy[0], 0);

      // 8E1 / 8O1 0x07
      chk("model_e07", frame_of(1, 9'h07), 16'h060E);
      chk("model_o07", frame_of(2, 9'h07), 16'h040E);
      fork
         send(1, 9'h07, a1);
         send(2, 9'h07, a2);
      join
      at_cyc(a1 + 94);  chk("par_even", line[1], 1); chk("par_odd", line[2], 0);
      at_cyc(a1 + 109); chk("p_ready_last", ready[1], 1);
      at_cyc(a1 + 110); chk("p_done_e", done[1], 1); chk("p_done_o", done[2], 1);

      // 7N2 back-to-back with valid held
      chk("model_7n2_55", frame_of(3, 9'h55), 16'h03AA);
      @(posedge clk); #1;
      valid[3] = 1'b1; data[3] = 9'h55; n0 = acc_cnt[3];
      wait_acc(3, n0, a);
      data[3] = 9'h2A;
      wait_acc(3, n0 + 1, b);
      valid[3] = 1'b0;
      chk("b2b_spacing", b - a, 100);
      at_cyc(a + 100); chk("b2b_done1", done[3], 1); chk("b2b_nogap", line[3], 0);
      at_cyc(a + 200); chk("b2b_done2", done[3], 1);

      // Reset at cycle 37 of a 0x00 frame
      send(0, 9'h00, a);
      to_edge(a + 36);
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("abort_line", line[0], 1); chk("abort_ready", ready[0], 1); chk("abort_busy", busy[0], 0);
      z = 0;
      for (int k = 0; k < 100; k++) begin @(negedge clk); if (done[0] === 1'b1) z++; end
      chk("abort_no_done", z, 0);
      send(0, 9'h3C, a);
      at_cyc(a + 105);

      // tx_data changes right after acceptance
      send(0, 9'h0FF, a);
      data[0] = 9'h000;
      for (int k = 1; k <= 8; k++) begin
         at_cyc(a + k * 10 + 4);
         chk($sformatf("hold_ff_bit%0d", k), line[0], 1);
      end
      at_cyc(a + 105);

`ifdef UART_TX_BREAK_EN
      @(posedge clk); #1;
      brk[0] = 1'b1; b = cyc; z = 0;
      fork
         begin to_edge(b + 50); brk[0] = 1'b0; end
         begin
            for (int k = 0; k <= 50; k++) begin
               at_cyc(b + k);
               chk($sformatf("brk_ready%0d", k), ready[0], 0);
               if (k > 0 && line[0] === 1'b0) z++;
            end
         end
      join
      chk("brk_low_cycles", z, 50);
      at_cyc(b + 51); chk("brk_end_line", line[0], 1); chk("brk_end_ready", ready[0], 1);
      send(0, 9'h5A, a);
      to_edge(a + 20); brk[0] = 1'b1;
      to_edge(a + 90); brk[0] = 1'b0;
      at_cyc(a + 100); chk("brk_mid_done", done[0], 1);
      at_cyc(a + 105);
`endif

      at_cyc(cyc + 5);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
